// File: rtl/ppu_stream.sv
// Streaming multi-lane post-processing unit: per-channel bias, multiply, rounding shift,
// saturation, zero point and optional ReLU over a 6-stage stall-frozen pipeline.
module ppu_stream #(
  parameter int LANES     = 4,
  parameter int ACC_W     = 32,
  parameter int M_W       = 27,
  parameter int OUT_W     = 8,
  parameter int N_CH      = 64,
  parameter int TAG_WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(N_CH)-1:0]      cfg_addr,
  input  logic [ACC_W-1:0]             cfg_bias,
  input  logic [M_W-1:0]               cfg_m,
  input  logic [5:0]                   cfg_s,
  input  logic [$clog2(N_CH):0]        cfg_nch,
  input  logic [OUT_W-1:0]             cfg_z,
  input  logic                         cfg_relu,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [LANES*ACC_W-1:0]       s_data,
  input  logic                         s_last,
  input  logic [TAG_WIDTH-1:0]         s_tag,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [LANES*OUT_W-1:0]       m_data,
  output logic [TAG_WIDTH-1:0]         m_tag
);

  localparam int AW   = $clog2(N_CH);
  localparam int E_W  = ACC_W + M_W + 6;
  localparam int S_W  = ACC_W + 1;
  localparam int LO   = M_W / 2;
  localparam int HI_W = M_W - LO;
  localparam int PL_W = S_W + LO + 1;
  localparam int PH_W = S_W + HI_W;
  localparam int P_W  = S_W + M_W;
  localparam int Q_W  = OUT_W + 1;
  localparam int T_W  = OUT_W + 2;
  localparam logic signed [P_W-1:0] PHI = P_W'((1 << OUT_W) - 1);
  localparam logic signed [P_W-1:0] PLO = P_W'(-(1 << OUT_W));

  logic [E_W-1:0] tbl [N_CH];

  logic stall, en, accept;
  logic [AW-1:0] ch;
  logic [AW:0]   nch_last;

  logic v1, v2, v3, v4, v5;
  logic [TAG_WIDTH-1:0] t1, t2, t3, t4, t5;

  logic [E_W-1:0]          ent1;
  logic signed [ACC_W-1:0] bias1;
  logic signed [M_W-1:0]   m1, m2;
  logic [5:0]              s1, s2, s3, s4;

  logic signed [ACC_W-1:0] acc1 [LANES];
  logic signed [S_W-1:0]   sum2 [LANES];
  logic signed [PL_W-1:0]  pl3  [LANES];
  logic signed [PH_W-1:0]  ph3  [LANES];
  logic signed [P_W-1:0]   p4   [LANES];
  logic signed [Q_W-1:0]   qc   [LANES];
  logic signed [Q_W-1:0]   q5   [LANES];
  logic [LANES*OUT_W-1:0]  o6;

  assign stall   = m_valid && !m_ready;
  assign en      = !stall;
  assign s_ready = !stall && !rst;
  assign accept  = s_valid && s_ready;

  assign bias1 = ent1[E_W-1 -: ACC_W];
  assign m1    = ent1[M_W+5:6];
  assign s1    = ent1[5:0];

  // A zero channel count means the full table depth.
  always_comb begin
    nch_last = cfg_nch - 1'b1;
    if (cfg_nch == '0) nch_last = (AW+1)'(N_CH - 1);
  end

  // Write and read share an edge; the read register sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (cfg_we) tbl[cfg_addr] <= {cfg_bias, cfg_m, cfg_s};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch      <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      v4      <= 1'b0;
      v5      <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
    end else if (en) begin
      v1      <= accept;
      v2      <= v1;
      v3      <= v2;
      v4      <= v3;
      v5      <= v4;
      m_valid <= v5;
      m_data  <= o6;
      m_tag   <= t5;
      if (accept) ch <= (s_last || ({1'b0, ch} == nch_last)) ? '0 : ch + 1'b1;
    end
  end

  // Multiplier is split into an unsigned low half and a signed high half across two stages.
  always_ff @(posedge clk) begin
    if (en) begin
      ent1 <= tbl[ch];
      t1   <= s_tag;
      m2   <= m1;
      s2   <= s1;
      t2   <= t1;
      s3   <= s2;
      t3   <= t2;
      s4   <= s3;
      t4   <= t3;
      t5   <= t4;
      for (int unsigned i = 0; i < LANES; i++) begin
        acc1[i] <= s_data[i*ACC_W +: ACC_W];
        sum2[i] <= S_W'(acc1[i]) + S_W'(bias1);
        pl3[i]  <= PL_W'(sum2[i]) * PL_W'($signed({1'b0, m2[LO-1:0]}));
        ph3[i]  <= PH_W'(sum2[i]) * PH_W'($signed(m2[M_W-1:LO]));
        p4[i]   <= (P_W'(ph3[i]) <<< LO) + P_W'(pl3[i]);
        q5[i]   <= qc[i];
      end
    end
  end

  always_comb begin
    logic signed [P_W-1:0] r, q, qq;
    for (int unsigned i = 0; i < LANES; i++) begin
      r = '0;
      q = p4[i];
      if (s4 != 6'd0) begin
        r = p4[i] >>> (s4 - 6'd1);
        q = (r >>> 1) + $signed({{(P_W-1){1'b0}}, r[0]});
      end
      qq = q;
      if (q > PHI)      qq = PHI;
      else if (q < PLO) qq = PLO;
      qc[i] = qq[Q_W-1:0];
    end
  end

  always_comb begin
    logic [T_W-1:0]   t;
    logic [OUT_W-1:0] o;
    o6 = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      t = {q5[i][Q_W-1], q5[i]} + {2'b00, cfg_z};
      if (t[T_W-1])      o = '0;
      else if (t[OUT_W]) o = '1;
      else               o = t[OUT_W-1:0];
      if (cfg_relu && (o < cfg_z)) o = cfg_z;
      o6[i*OUT_W +: OUT_W] = o;
    end
  end

endmodule

// File: doc/ppu_stream.md
# ppu_stream

Streaming, multi-lane successor to the single-lane post-processing unit. Each beat carries `LANES` signed accumulators belonging to one output channel. The block applies that channel's bias, multiplier, shift and rounding, saturates the result, adds the zero point, and optionally applies ReLU. It sits between the conv accumulator drain and the output write-back buffer, with valid/ready handshakes on both sides and a runtime-loadable per-channel parameter table.

## Interface
Parameters:
- `LANES`, 4, accumulators per beat (pixels sharing one channel)
- `ACC_W`, 32, signed accumulator and bias width
- `M_W`, 27, signed multiplier width
- `OUT_W`, 8, unsigned output width
- `N_CH`, 64, parameter-table depth (power of 2)
- `TAG_WIDTH`, 1, sideband tag carried with each beat

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `cfg_we` in 1: table write strobe
- `cfg_addr` in log2(N_CH): table write address
- `cfg_bias` in ACC_W: signed bias
- `cfg_m` in M_W: signed multiplier
- `cfg_s` in 6: right-shift amount
- `cfg_nch` in log2(N_CH)+1: active channel count, 1..N_CH; static while streaming
- `cfg_z` in OUT_W: zero point; static while streaming
- `cfg_relu` in 1: clamp output at or above `cfg_z`; static while streaming
- `s_valid` in 1, `s_ready` out 1: input handshake
- `s_data` in LANES*ACC_W: lane i occupies bits [i*ACC_W +: ACC_W]
- `s_last` in 1: last beat of a channel group
- `s_tag` in TAG_WIDTH: input tag
- `m_valid` out 1, `m_ready` in 1: output handshake
- `m_data` out LANES*OUT_W: lane i occupies bits [i*OUT_W +: OUT_W]
- `m_tag` out TAG_WIDTH: tag of the output beat

## Operation
- A beat is accepted on `s_valid && s_ready`. It uses the table entry at channel counter `ch`.
- `ch` resets to 0. After each accepted beat it increments. It wraps to 0 after `cfg_nch-1`, or after any accepted beat with `s_last=1`, whichever comes first.
- Per-lane arithmetic, full precision, no intermediate truncation:
  - `sum = acc + bias`, ACC_W+1 bits.
  - `p = sum * m`, signed.
  - If `s = 0`: `q = p`.
  - If `s > 0`: `r = p >>> (s-1)` and `q = (r >>> 1) + r[0]`. This rounds half toward +inf.
  - Clamp `q` to [-2^OUT_W, 2^OUT_W - 1].
  - `o = clamp(q + z, 0, 2^OUT_W - 1)`.
  - If `cfg_relu=1`: `o = max(o, z)`.
- The table is a synchronous-write, synchronous-read RAM and is not cleared by reset.
- A write takes effect for beats accepted on the cycle after the write or later. A beat accepted in the same cycle as a write to its channel uses the old value.
- Tag and lane data travel together. Beats are never reordered, dropped or duplicated.

## Timing
- Pipeline is 6 stages:
  1. table read / input register
  2. bias add
  3. multiply stage 1
  4. multiply stage 2
  5. shift/round/clamp
  6. zero point / ReLU output register
- With no stall, a beat accepted at cycle t appears with `m_valid=1` at t+6.
- Throughput is one beat per cycle while `m_ready=1`.
- `stall = m_valid && !m_ready`. A stall freezes every stage and `ch`.
- `s_ready = !stall`, combinational from `m_ready`. `s_ready` is also 0 during reset.
- `m_data` and `m_tag` hold stable while `m_valid && !m_ready`.
- Reset values: `m_valid`=0, `m_data`=0, `m_tag`=0, all internal valid bits 0, `ch`=0.
- Reset mid-stream discards all in-flight beats. No output is produced for them.
- `cfg_nch=0` is illegal. The block treats it as N_CH.

## Test plan
- Nominal: LANES=4, ch0 = {bias=28, m=16384, s=15}, z=10, all lanes acc=100 -> after 6 cycles, every lane = 74.
- Rounding: bias=0, m=1, s=1, z=0, lanes {1, -1, 3, -3} -> {1, 0, 2, -1 clamped to 0}. With z=128: {129, 128, 130, 127}.
- Saturation and ReLU, m=1, s=0:
  - acc=1000000, z=0 -> 255.
  - acc=-1000, z=10 -> 0.
  - acc=-5, z=10, relu=0 -> 5.
  - acc=-5, z=10, relu=1 -> 10.
- Channel wrap: `cfg_nch`=3, per-channel biases {0, 1, 2}, acc=0, m=1, s=0, z=0:
  - 7 beats -> outputs 0,1,2,0,1,2,0.
  - Repeat with `s_last` on beat 2 -> 0,1,0,1,2,0,1.
- Backpressure: continuous `s_valid`, random `m_ready` (30% low, including a 10-cycle low run), 200 beats with incrementing tags -> output tag sequence is exact, `s_ready`=0 exactly when stalled, data is stable while stalled.
- Table write and reset: write ch0 bias in the same cycle a ch0 beat is accepted -> that beat uses the old bias and the next ch0 beat uses the new one. Assert `rst` with 4 beats in flight -> `m_valid`=0 the next cycle, no stale beat emitted, the next accepted beat uses ch0.
